// File: rtl/uncache_dm_unit.sv
// Uncached data-memory access engine: takes one load/store from MEM1 and issues a single-beat
// request on the rd/wr bus, then waits for read data or write completion before going idle again.
module uncache_dm_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [DATA_W-1:0] ret_data,
    input  logic              wr_rdy,
    input  logic              wr_done,
    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_req,
    output logic [2:0]        wr_type,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [DATA_W-1:0] wr_data,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields are captured only on acceptance, so they stay stable while the bus stalls.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    addr_d  = addr;
                    size_d  = size;
                    wstrb_d = wstrb;
                    wdata_d = wdata;
                    state_d = op ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (rd_rdy) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (ret_valid) begin
                    rdata_d = ret_data;
                    if (ret_last) state_d = S_IDLE;
                end
            end
            S_WR_REQ: begin
                if (wr_rdy) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (wr_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs come from flops or state decode only; nothing combinational from the inputs.
    assign rd_req   = (state_q == S_RD_REQ);
    assign wr_req   = (state_q == S_WR_REQ);
    assign data_ok  = (state_q == S_IDLE);
    assign rd_type  = {1'b0, size_q};
    assign wr_type  = {1'b0, size_q};
    assign rd_addr  = addr_q;
    assign wr_addr  = addr_q;
    assign wr_wstrb = wstrb_q;
    assign wr_data  = wdata_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_uncache_dm_unit.sv
// Bench for uncache_dm_unit: each transaction is predicted as a cycle timeline (accept, request
// phase lasting stall+1 cycles, response wait, idle) and every cycle's outputs are compared to it.
module tb_uncache_dm_unit;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic        op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
    logic        wr_rdy;
    logic        wr_done;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        wr_req;
    logic [2:0]  wr_type;
    logic [31:0] wr_addr;
    logic [3:0]  wr_wstrb;
    logic [31:0] wr_data;
    logic        data_ok;
    logic [31:0] rdata;

    int          n_checks;
    int          n_fails;
    logic [31:0] exp_rdata;

    uncache_dm_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op), .addr(addr), .size(size),
        .wstrb(wstrb), .wdata(wdata), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
        .ret_last(ret_last), .ret_data(ret_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .wr_req(wr_req),
        .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .data_ok(data_ok), .rdata(rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        valid = 0; op = 0; addr = 0; size = 0; wstrb = 0; wdata = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0; wr_done = 0;
    endtask

    // One transaction: d = request-phase stall cycles, r = extra wait cycles before the final
    // response. mid_mode: 0 no early beats, 1 random non-last beats, 2 every early cycle beats mid_d.
    task automatic run_txn(input bit op_i, input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] sb, input logic [31:0] wd, input int d, input int r,
                           input int mid_mode, input logic [31:0] mid_d, input logic [31:0] last_d,
                           input bit busy_valid, input string name);
        int endc;
        bit exp_ok, exp_rd, exp_wr;
        endc = d + 3 + r;
        for (int c = 0; c <= endc; c++) begin
            @(negedge clk);
            exp_ok = (c == 0) || (c == endc);
            exp_rd = !op_i && (c >= 1) && (c <= d + 1);
            exp_wr = op_i && (c >= 1) && (c <= d + 1);
            n_checks++;
            if (data_ok !== exp_ok) begin
                n_fails++;
                $display("FAIL %s data_ok cycle %0d: got %b want %b", name, c, data_ok, exp_ok);
            end
            n_checks++;
            if (rd_req !== exp_rd) begin
                n_fails++;
                $display("FAIL %s rd_req cycle %0d: got %b want %b", name, c, rd_req, exp_rd);
            end
            n_checks++;
            if (wr_req !== exp_wr) begin
                n_fails++;
                $display("FAIL %s wr_req cycle %0d: got %b want %b", name, c, wr_req, exp_wr);
            end
            n_checks++;
            if (rdata !== exp_rdata) begin
                n_fails++;
                $display("FAIL %s rdata cycle %0d: got %h want %h", name, c, rdata, exp_rdata);
            end
            if (exp_rd) begin
                n_checks++;
                if (rd_addr !== a || rd_type !== {1'b0, sz}) begin
                    n_fails++;
                    $display("FAIL %s rd fields cycle %0d: got %h/%b want %h/%b",
                             name, c, rd_addr, rd_type, a, {1'b0, sz});
                end
            end
            if (exp_wr) begin
                n_checks++;
                if (wr_addr !== a || wr_type !== {1'b0, sz} || wr_wstrb !== sb || wr_data !== wd) begin
                    n_fails++;
                    $display("FAIL %s wr fields cycle %0d: got %h/%b/%b/%h want %h/%b/%b/%h",
                             name, c, wr_addr, wr_type, wr_wstrb, wr_data, a, {1'b0, sz}, sb, wd);
                end
            end
            // Background noise: unrelated strobes that the current state must ignore.
            valid = 0; op = 1'($urandom); addr = $urandom; size = 2'($urandom);
            wstrb = 4'($urandom); wdata = $urandom;
            rd_rdy = op_i ? 1'($urandom) : 1'b0;
            wr_rdy = op_i ? 1'b0 : 1'($urandom);
            ret_valid = 1'($urandom); ret_last = 1'($urandom); ret_data = $urandom;
            wr_done = op_i ? 1'b0 : 1'($urandom);
            if (c == 0) begin
                valid = 1; op = op_i; addr = a; size = sz; wstrb = sb; wdata = wd;
            end else if (c < endc && (busy_valid || ($urandom % 2 == 1))) begin
                valid = 1;
            end
            if (c == endc) valid = 0;
            if (c == d + 1) begin
                if (op_i) wr_rdy = 1; else rd_rdy = 1;
            end
            if (c >= d + 2 && c <= d + 2 + r) begin
                if (op_i) begin
                    wr_done = (c == d + 2 + r);
                end else if (c == d + 2 + r) begin
                    ret_valid = 1; ret_last = 1; ret_data = last_d;
                end else begin
                    ret_last = 0;
                    if (mid_mode == 0) ret_valid = 0;
                    else if (mid_mode == 2) begin ret_valid = 1; ret_data = mid_d; end
                end
                if (!op_i && ret_valid) exp_rdata = ret_data;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        #12;
        resetn = 1;
        exp_rdata = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (data_ok !== 1'b1 || rd_req !== 1'b0 || wr_req !== 1'b0) begin
                n_fails++;
                $display("FAIL reset ctrl: got ok=%b rd=%b wr=%b want 1/0/0", data_ok, rd_req, wr_req);
            end
            n_checks++;
            if (rdata !== 32'h0 || rd_addr !== 32'h0 || wr_data !== 32'h0 ||
                wr_wstrb !== 4'h0 || rd_type !== 3'b0) begin
                n_fails++;
                $display("FAIL reset regs: got rdata=%h addr=%h wdata=%h strb=%b type=%b want zeros",
                         rdata, rd_addr, wr_data, wr_wstrb, rd_type);
            end
        end
    endtask

    task automatic test_load_basic();
        run_txn(1'b0, 32'h1FAF_0010, 2'd2, 4'hF, 32'h0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 1'b0, "load_basic");
    endtask

    task automatic test_store_stall();
        run_txn(1'b1, 32'h1FAF_F003, 2'd0, 4'b1000, 32'h1122_3344, 4, 1, 0, 32'h0, 32'h0, 1'b0, "store_stall");
    endtask

    task automatic test_busy_valid();
        run_txn(1'b0, 32'h0000_1230, 2'd1, 4'h3, 32'h0, 1, 3, 0, 32'h0, 32'hCAFE_F00D, 1'b1, "busy_valid");
        run_txn(1'b0, 32'h0000_4560, 2'd2, 4'hF, 32'h0, 0, 0, 0, 32'h0, 32'h0BAD_CAFE, 1'b0, "after_busy");
    endtask

    task automatic test_multibeat();
        run_txn(1'b0, 32'h1FAF_0020, 2'd2, 4'hF, 32'h0, 0, 1, 2, 32'hAAAA_0000, 32'h0000_5555, 1'b0, "multibeat");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom), $urandom, 2'($urandom_range(0, 2)), 4'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1, 32'h0, $urandom,
                    1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        valid = 1; op = 1; addr = 32'h1FAF_0100; size = 2'd2; wstrb = 4'hF; wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        valid = 0; wr_rdy = 1;
        n_checks++;
        if (wr_req !== 1'b1) begin
            n_fails++;
            $display("FAIL rstmid wr_req before reset: got %b want 1", wr_req);
        end
        @(negedge clk);
        wr_rdy = 0;
        #2 resetn = 0;
        #1;
        exp_rdata = 0;
        n_checks++;
        if (data_ok !== 1'b1 || wr_req !== 1'b0 || wr_addr !== 32'h0 || rdata !== 32'h0) begin
            n_fails++;
            $display("FAIL rstmid async: got ok=%b wr=%b addr=%h rdata=%h want 1/0/0/0",
                     data_ok, wr_req, wr_addr, rdata);
        end
        @(negedge clk);
        resetn = 1; wr_done = 1;
        @(negedge clk);
        wr_done = 0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (data_ok !== 1'b1 || wr_req !== 1'b0 || rd_req !== 1'b0) begin
                n_fails++;
                $display("FAIL rstmid late wr_done: got ok=%b wr=%b rd=%b want 1/0/0",
                         data_ok, wr_req, rd_req);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        exp_rdata = 0;
        test_reset();
        test_load_basic();
        test_store_stall();
        test_busy_valid();
        test_multibeat();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
